la_seq_ctrl: RTL

Sequencer for the 5x5 linear-algebra matrix core: accepts a 25-element input stream, writes the core's element registers in row-major address order 0..24, pulses the core start, waits for completion, then reads all 25 result elements back out as a valid/ready stream. It sits between the host-side stream interface and the matrix core's address/data port, so no host ever drives core addresses directly.

---
 rtl/la_seq_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/la_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : la_seq_ctrl
// Purpose  : Load / compute / readout sequencer for the 5x5 matrix core.
//            Optional WAIT timeout enabled by defining LA_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module la_seq_ctrl #(
  parameter int N       = 5,
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [AW-1:0] core_addr,
  output logic          core_wr_en,
  output logic [DW-1:0] core_wr_data,
  output logic          core_go,
  input  logic          core_done,
  input  logic [DW-1:0] core_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int            C_E    = N * N;
  localparam logic [AW-1:0] C_LAST = AW'(C_E - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GO     = 3'd2,
    S_WAIT   = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_CAP = 3'd5,
    S_RD_OUT = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_k;
  logic [AW-1:0] w_k_next;
  logic [DW-1:0] r_out_data;
  logic          r_done;
  logic          w_timeout;

`ifdef LA_SEQ_TIMEOUT_EN
  localparam int C_TW = $clog2(TIMEOUT + 1);

  logic [C_TW-1:0] r_wait_cnt;

  // Counts cycles spent in WAIT; zero on the first WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !core_done &&
                     (r_wait_cnt == C_TW'(TIMEOUT - 1));
  assign err       = (r_state == S_ERR);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_out_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_k     <= w_k_next;
      r_done  <= (r_state == S_RD_OUT) && out_ready && (r_k == C_LAST);
      if (r_state == S_RD_CAP) begin
        r_out_data <= core_rd_data;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_k_next = r_k;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (start) begin
          w_next   = S_LOAD;
          w_k_next = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (r_k == C_LAST) begin
            w_next   = S_GO;
            w_k_next = '0;
          end else begin
            w_k_next = r_k + 1'b1;
          end
        end
      end
      S_GO: w_next = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          w_next   = S_RD_REQ;
          w_k_next = '0;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_RD_REQ: w_next = S_RD_CAP;
      S_RD_CAP: w_next = S_RD_OUT;
      S_RD_OUT: begin
        if (out_ready) begin
          if (r_k == C_LAST) begin
            w_next   = S_IDLE;
            w_k_next = '0;
          end else begin
            w_next   = S_RD_REQ;
            w_k_next = r_k + 1'b1;
          end
        end
      end
      default: begin
        w_next   = S_IDLE;
        w_k_next = '0;
      end
    endcase
  end

  // All handshake/strobe outputs decode the state so reset clears them at once.
  assign busy         = (r_state != S_IDLE) && (r_state != S_ERR);
  assign done         = r_done;
  assign in_ready     = (r_state == S_LOAD);
  assign core_addr    = r_k;
  assign core_wr_en   = (r_state == S_LOAD) && in_valid;
  assign core_wr_data = (r_state == S_LOAD) ? in_data : '0;
  assign core_go      = (r_state == S_GO);
  assign out_valid    = (r_state == S_RD_OUT);
  assign out_data     = r_out_data;
  assign out_last     = (r_state == S_RD_OUT) && (r_k == C_LAST);

endmodule
`default_nettype wire
